// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between the fetch (IF) and MEM-stage (ME)
//            requesters. ME has fixed priority, one transaction in flight.
// Options  : ARB_TIMEOUT_EN adds a REQ/WAIT watchdog with an err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_stall_o,

    input  logic                me_req_i,
    input  logic                me_we_i,
    input  logic [ADDR_W-1:0]   me_addr_i,
    input  logic [DATA_W-1:0]   me_wdata_i,
    input  logic [DATA_W/8-1:0] me_be_i,
    output logic                me_rvalid_o,
    output logic [DATA_W-1:0]   me_rdata_o,
    output logic                me_stall_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                err_o
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_me_q;
    logic                kill_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                if_rvalid_q;
    logic                me_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   me_rdata_q;

    logic                sel_me;
    logic                sel_if;
    logic                kill_d;
    logic                resp_d;
    logic                tmo;
    logic                end_d;
    logic [DATA_W-1:0]   resp_data_d;

    // A requester pulsing rvalid this cycle is not eligible again until the next one
    assign sel_me = (state_q == ST_IDLE) && me_req_i && !me_rvalid_q;
    assign sel_if = (state_q == ST_IDLE) && !sel_me && if_req_i && !if_rvalid_q;

    // A flush arriving together with the memory response still suppresses it
    assign kill_d = kill_q || (if_flush_i && !owner_me_q && (state_q != ST_IDLE));

    assign resp_d      = (state_q == ST_WAIT) && mem_rvalid_i;
    assign end_d       = resp_d || tmo;
    assign resp_data_d = resp_d ? mem_rdata_i : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign tmo   = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo && !resp_d;
            if (state_q == ST_IDLE || end_d) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign tmo                = 1'b0;
    assign err_o              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_me_q  <= 1'b0;
            kill_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_rvalid_q <= 1'b0;
            me_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            me_rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_me) begin
                        state_q    <= ST_REQ;
                        owner_me_q <= 1'b1;
                        kill_q     <= 1'b0;
                        we_q       <= me_we_i;
                        addr_q     <= me_addr_i;
                        wdata_q    <= me_wdata_i;
                        be_q       <= me_be_i;
                    end else if (sel_if) begin
                        state_q    <= ST_REQ;
                        owner_me_q <= 1'b0;
                        kill_q     <= if_flush_i;
                        we_q       <= 1'b0;
                        addr_q     <= if_addr_i;
                        wdata_q    <= '0;
                        be_q       <= '1;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    kill_q <= kill_d;
                    if (end_d) begin
                        state_q <= ST_IDLE;
                        kill_q  <= 1'b0;
                        if (owner_me_q) begin
                            me_rvalid_q <= 1'b1;
                            me_rdata_q  <= resp_data_d;
                        end else if (!kill_d) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= resp_data_d;
                        end
                    end else if (state_q == ST_REQ && mem_gnt_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign me_rvalid_o = me_rvalid_q;
    assign me_rdata_o  = me_rdata_q;

    assign if_stall_o  = if_req_i && !if_rvalid_q;
    assign me_stall_o  = me_req_i && !me_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scenarios plus a randomized run scored against a
//            transaction-level model of the two requesters and the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_rvalid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        me_req, me_we, me_rvalid, me_stall;
    logic [31:0] me_addr, me_wdata, me_rdata;
    logic [3:0]  me_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_flush_i   (if_flush),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .if_stall_o   (if_stall),
        .me_req_i     (me_req),
        .me_we_i      (me_we),
        .me_addr_i    (me_addr),
        .me_wdata_i   (me_wdata),
        .me_be_i      (me_be),
        .me_rvalid_o  (me_rvalid),
        .me_rdata_o   (me_rdata),
        .me_stall_o   (me_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .err_o        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] if_rand_addr();
        logic [31:0] a;
        a = $urandom;
        return {1'b0, a[30:2], 2'b00};
    endfunction

    function automatic logic [31:0] me_rand_addr();
        logic [31:0] a;
        a = $urandom;
        return {1'b1, a[30:2], 2'b00};
    endfunction

    // Random-phase model state
    bit          txn_v, txn_me, txn_g, txn_kill;
    bit          exp_if, exp_me, exp_me_wr, got_if, got_me, me_hold, prev_me_elig;
    int          gwait, dly, if_age, me_age;
    logic [31:0] cap_addr, exp_if_d, exp_me_d, last_if_d, last_me_d;
    logic [3:0]  rb;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        me_req = 0; me_we = 0; me_addr = 0; me_wdata = 0; me_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        // Reset: outputs quiet during and after reset
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_me_rvalid", me_rvalid, 0);
        check("rst_err", err, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_me_rdata", me_rdata, 0);
        rst = 1'b0;
        tick();
        check("rst1_mem_req", mem_req, 0);
        check("rst1_rvalid", {if_rvalid, me_rvalid, err}, 0);

        // Single fetch at minimum latency
        if_req = 1; if_addr = 32'h100; #1;
        check("f_stall_n", if_stall, 1);
        tick();
        check("f_mem_req", mem_req, 1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_we", mem_we, 0);
        check("f_mem_be", mem_be, 4'hF);
        check("f_stall_n1", if_stall, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        check("f_req_one_cycle", mem_req, 0);
        check("f_stall_n2", if_stall, 1);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        check("f_if_rvalid", if_rvalid, 1);
        check("f_if_rdata", if_rdata, 32'hDEADBEEF);
        check("f_stall_n3", if_stall, 0);
        if_req = 0;
        tick();
        check("f_rvalid_pulse", if_rvalid, 0);
        check("f_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests: ME write first, then IF read
        if_req = 1; if_addr = 32'h400;
        me_req = 1; me_we = 1; me_addr = 32'h200; me_wdata = 32'h55; me_be = 4'hF;
        tick();
        check("p_mem_we", mem_we, 1);
        check("p_mem_addr", mem_addr, 32'h200);
        check("p_mem_wdata", mem_wdata, 32'h55);
        check("p_mem_be", mem_be, 4'hF);
        check("p_if_stall1", if_stall, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1;
        check("p_if_stall2", if_stall, 1);
        tick();
        mem_rvalid = 0;
        check("p_me_rvalid", me_rvalid, 1);
        check("p_if_rvalid0", if_rvalid, 0);
        check("p_if_stall3", if_stall, 1);
        me_req = 0; me_we = 0;
        tick();
        check("p_if_mem_req", mem_req, 1);
        check("p_if_mem_addr", mem_addr, 32'h400);
        check("p_if_mem_we", mem_we, 0);
        check("p_if_stall4", if_stall, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
        check("p_if_stall5", if_stall, 1);
        tick();
        mem_rvalid = 0;
        check("p_if_rvalid", if_rvalid, 1);
        check("p_if_rdata", if_rdata, 32'hCAFE0001);
        if_req = 0;
        tick();

        // Flush while the fetch is in WAIT
        if_req = 1; if_addr = 32'h500;
        tick();
        check("k_mem_req", mem_req, 1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; if_flush = 1; if_addr = 32'h600;
        tick();
        if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
        tick();
        mem_rvalid = 0;
        check("k_no_rvalid", if_rvalid, 0);
        check("k_idle", mem_req, 0);
        check("k_rdata_hold", if_rdata, 32'hCAFE0001);
        tick();
        check("k_next_req", mem_req, 1);
        check("k_next_addr", mem_addr, 32'h600);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hABCD;
        tick();
        mem_rvalid = 0;
        check("k_next_rvalid", if_rvalid, 1);
        check("k_next_rdata", if_rdata, 32'hABCD);
        if_req = 0;
        tick();

        // Grant withheld for five cycles, with a stray rvalid in REQ
        me_req = 1; me_we = 0; me_addr = 32'h700; me_be = 4'hF; me_wdata = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("g_req_stable", mem_req, 1);
            check("g_addr_stable", mem_addr, 32'h700);
            check("g_no_rvalid", me_rvalid, 0);
            mem_rvalid = (k == 2);
            mem_rdata  = 32'hBAD0BAD0;
            tick();
        end
        mem_rvalid = 0;
        check("g_req_last", mem_req, 1);
        check("g_stray_ignored", me_rvalid, 0);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        check("g_req_drop", mem_req, 0);
        mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        mem_rvalid = 0;
        check("g_me_rvalid", me_rvalid, 1);
        check("g_me_rdata", me_rdata, 32'h77);
        me_req = 0;
        tick();

        // Reset in WAIT, late response afterwards
        me_req = 1; me_addr = 32'h800;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0; rst = 1; me_req = 0;
        tick();
        rst = 0;
        check("r_mem_req", mem_req, 0);
        check("r_me_rvalid", me_rvalid, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hBAD;
        check("r_mem_req2", mem_req, 0);
        tick();
        mem_rvalid = 0;
        check("r_late_ignored", {if_rvalid, me_rvalid}, 0);
        check("r_idle", mem_req, 0);
        check("r_me_rdata", me_rdata, 0);
        me_req = 1; me_addr = 32'h900;
        tick();
        check("r_new_req", mem_req, 1);
        check("r_new_addr", mem_addr, 32'h900);
        mem_gnt = 1;
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        tick();
        mem_rvalid = 0;
        check("r_new_rvalid", me_rvalid, 1);
        check("r_new_rdata", me_rdata, 32'h99);
        me_req = 0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: response never arrives
        begin
            int cycles;
            me_req = 1; me_addr = 32'hA00; me_we = 0;
            tick();
            check("t_mem_req", mem_req, 1);
            mem_gnt = 1;
            tick();
            mem_gnt = 0;
            cycles = 0;
            while (!me_rvalid && cycles < 40) begin
                check("t_no_err_early", err, 0);
                tick();
                cycles++;
            end
            check("t_latency", cycles, TMO - 1);
            check("t_me_rvalid", me_rvalid, 1);
            check("t_err", err, 1);
            check("t_me_rdata", me_rdata, 0);
            me_req = 0;
            tick();
            check("t_err_pulse", err, 0);
            check("t_idle", mem_req, 0);
        end
`endif

        // Randomized traffic against a transaction-level model
        rst = 1;
        tick();
        rst = 0;
        txn_v = 0; txn_me = 0; txn_g = 0; txn_kill = 0;
        exp_if = 0; exp_me = 0; exp_me_wr = 0; me_hold = 1; prev_me_elig = 0;
        gwait = 0; dly = 0; if_age = 0; me_age = 0;
        last_if_d = 0; last_me_d = 0; cap_addr = 0; exp_if_d = 0; exp_me_d = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            got_if = exp_if;
            got_me = exp_me;
            check("rnd_if_rvalid", if_rvalid, exp_if);
            if (exp_if) begin
                check("rnd_if_rdata", if_rdata, exp_if_d);
                last_if_d = exp_if_d;
            end else begin
                check("rnd_if_hold", if_rdata, last_if_d);
            end
            check("rnd_me_rvalid", me_rvalid, exp_me);
            if (exp_me) begin
                me_hold = !exp_me_wr;
                if (!exp_me_wr) begin
                    check("rnd_me_rdata", me_rdata, exp_me_d);
                    last_me_d = exp_me_d;
                end
            end else if (me_hold) begin
                check("rnd_me_hold", me_rdata, last_me_d);
            end
            check("rnd_err", err, 0);

            // Memory-side observation
            if (txn_v && !txn_g) begin
                check("rnd_req_held", mem_req, 1);
                check("rnd_addr_stable", mem_addr, cap_addr);
            end else if (txn_v) begin
                check("rnd_req_drop", mem_req, 0);
            end else if (mem_req) begin
                txn_v = 1; txn_g = 0; txn_kill = 0; gwait = 0;
                txn_me = mem_addr[31];
                if (txn_me) begin
                    check("rnd_me_owner", me_req, 1);
                    check("rnd_me_addr", mem_addr, me_addr);
                    check("rnd_me_we", mem_we, me_we);
                    check("rnd_me_be", mem_be, me_be);
                    if (me_we) check("rnd_me_wdata", mem_wdata, me_wdata);
                    cap_addr = me_addr;
                end else begin
                    check("rnd_if_owner", if_req, 1);
                    check("rnd_if_addr", mem_addr, if_addr);
                    check("rnd_if_we", mem_we, 0);
                    check("rnd_if_be", mem_be, 4'hF);
                    check("rnd_prio", prev_me_elig, 0);
                    cap_addr = if_addr;
                end
            end

            // Requesters: new operations only when idle or just completed
            if (got_if || !if_req) begin
                if_req  = ($urandom % 3) != 0;
                if_addr = if_rand_addr();
            end
            if (got_me || !me_req) begin
                me_req   = ($urandom % 3) != 0;
                me_addr  = me_rand_addr();
                me_we    = $urandom % 2;
                me_wdata = $urandom;
                rb       = 4'($urandom);
                me_be    = (rb == 0) ? 4'h1 : rb;
            end

            // Flush: redirects an owned fetch, harmless otherwise
            if_flush = 0;
            if (txn_v && ($urandom % 5) == 0) begin
                if_flush = 1;
                if (!txn_me) begin
                    txn_kill = 1;
                    if_addr  = if_rand_addr();
                    if_age   = 0;
                end
            end

            // Memory responder
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            exp_if = 0; exp_me = 0;
            if (txn_v && !txn_g) begin
                mem_rvalid = ($urandom % 4) == 0;
                if (gwait >= 2 || ($urandom % 2) == 1) begin
                    mem_gnt = 1; txn_g = 1; dly = $urandom % 3;
                end else begin
                    gwait++;
                end
            end else if (txn_v) begin
                if (dly == 0) begin
                    mem_rvalid = 1;
                    if (txn_me) begin
                        exp_me = 1; exp_me_d = mem_rdata; exp_me_wr = me_we;
                    end else if (!txn_kill) begin
                        exp_if = 1; exp_if_d = mem_rdata;
                    end
                    txn_v = 0;
                end else begin
                    dly--;
                end
            end else begin
                mem_gnt    = ($urandom % 4) == 0;
                mem_rvalid = ($urandom % 4) == 0;
            end

            prev_me_elig = me_req && !got_me;
            if (got_if || !if_req) if_age = 0; else if_age++;
            if (got_me || !me_req) me_age = 0; else me_age++;
            check("rnd_if_live", (if_age > 30), 0);
            check("rnd_me_live", (me_age > 30), 0);
            #1;
            check("rnd_if_stall", if_stall, if_req && !got_if);
            check("rnd_me_stall", me_stall, me_req && !got_me);
        end

        if_req = 0; me_req = 0; if_flush = 0; mem_gnt = 0; mem_rvalid = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width in bits.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width in bits.
REQ-003 Parameter TIMEOUT_CYC, default 64, SHALL set the watchdog limit in cycles (only used under ARB_TIMEOUT_EN).
REQ-004 Clock and reset SHALL be: clk  in  1  single clock, all logic rising-edge; rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request, level, held until if_rvalid; if_addr  in  ADDR_W  fetch address.
REQ-006 if_flush  in  1  taken branch/jump; the pending fetch response is discarded.
REQ-007 me_req  in  1  MEM-stage request, level, held until me_rvalid; me_we  in  1  write; me_addr  in  ADDR_W; me_wdata  in  DATA_W; me_be  in  DATA_W/8  byte enables.
REQ-008 if_rvalid/me_rvalid  out  1  one-cycle completion pulse; if_rdata/me_rdata  out  DATA_W  read data.
REQ-009 if_stall/me_stall  out  1  to the hazard unit; equal to x_req AND NOT x_rvalid (combinational).
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8; mem_gnt  in  1  accept; mem_rvalid  in  1  response/write-ack; mem_rdata  in  DATA_W.
REQ-011 err  out  1  one-cycle timeout pulse.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT; at most one memory transaction outstanding.
REQ-013 IDLE: if me_req (and me_rvalid low) SHALL select ME; else if if_req (and if_rvalid low) SHALL select IF; selection is fixed priority, ME over IF.
REQ-014 On selection in cycle N, owner, addr, we, wdata, be SHALL be registered; state REQ in N+1; IF selection forces mem_we=0, mem_be all ones.
REQ-015 REQ: mem_req=1 with registered fields held stable until mem_gnt; on mem_req AND mem_gnt go to WAIT.
REQ-016 WAIT: mem_req=0; on mem_rvalid go to IDLE and, in the next cycle, pulse owner's x_rvalid for exactly one cycle with x_rdata=mem_rdata (writes: rdata don't-care, rvalid still pulses).
REQ-017 Minimum latency: request sampled N, mem_gnt at N+1, mem_rvalid at N+2 -> x_rvalid at N+3; peak one transaction per 3 cycles.
REQ-018 x_rdata SHALL hold its last value between pulses.
REQ-019 if_flush high in any cycle while owner is IF (REQ or WAIT, or the same cycle as IF selection) SHALL set a kill flag; the transaction completes on the memory side but if_rvalid SHALL NOT pulse; kill clears on return to IDLE.
REQ-020 if_flush while owner is ME or in IDLE with no IF selection SHALL have no effect.
REQ-021 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-022 A requester whose x_rvalid is high in the current cycle SHALL NOT be selected that cycle; a req still high next cycle is a new request.

Reset
REQ-023 rst SHALL force state IDLE, kill flag 0, timeout counter 0, registered fields 0.
REQ-024 During and the cycle after reset: mem_req=0, if_rvalid=0, me_rvalid=0, err=0, if_rdata=me_rdata=0.
REQ-025 Reset mid-transaction SHALL abandon it; any late mem_rvalid afterwards SHALL be ignored (REQ-021).

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: counter SHALL count cycles in REQ and WAIT; on reaching TIMEOUT_CYC, go to IDLE, drop mem_req, next cycle pulse owner's x_rvalid (unless killed) with x_rdata=0 and pulse err.
REQ-027 ARB_TIMEOUT_EN undefined: no counter; REQ/WAIT wait indefinitely; err tied 0.

Verification
REQ-028 if_req=1, if_addr=0x100, mem_gnt immediate, mem_rvalid next cycle with 0xDEADBEEF -> mem_req high one cycle with addr 0x100, if_rvalid at N+3 with 0xDEADBEEF, if_stall high N..N+2.
REQ-029 if_req and me_req (we=1, addr 0x200, wdata 0x55, be 0xF) same cycle -> ME write issued first, me_rvalid, then IF read issued; if_stall stays high throughout.
REQ-030 IF fetch in WAIT, if_flush pulsed, mem_rvalid returns 0x1234 -> no if_rvalid; FSM IDLE; next if_req served normally.
REQ-031 mem_gnt held low 5 cycles -> mem_req and mem_addr stable all 5 cycles; completion after gnt.
REQ-032 rst asserted in WAIT, mem_rvalid arrives 2 cycles later -> no x_rvalid, mem_req 0, FSM IDLE.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_rvalid never asserted on ME read -> me_rvalid and err pulse together with me_rdata=0, then IDLE.
